seg7_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for the 4-bit-to-7-segment hex decoder on the toy processor display.

---
 rtl/seg7_pkg.sv | 43 ++++
 rtl/seg7_hex_decode.sv | 30 +++
 rtl/seg7_scan_ctrl.sv | 159 +++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan controller: glyph table, segment bit order,
// digit-count limit and the pending-register state type.
package seg7_pkg;

  localparam int SEG_W      = 7;
  localparam int NIBBLE_W   = 4;
  localparam int MAX_DIGITS = 8;

  // Segment bit positions inside a glyph word {g,f,e,d,c,b,a}.
  localparam int SEG_IDX_A = 0;
  localparam int SEG_IDX_B = 1;
  localparam int SEG_IDX_C = 2;
  localparam int SEG_IDX_D = 3;
  localparam int SEG_IDX_E = 4;
  localparam int SEG_IDX_F = 5;
  localparam int SEG_IDX_G = 6;

  typedef logic [SEG_W-1:0] glyph_t;

  localparam glyph_t SEG_OFF = 7'h00;
  localparam glyph_t SEG_0   = 7'h3F;
  localparam glyph_t SEG_1   = 7'h06;
  localparam glyph_t SEG_2   = 7'h5B;
  localparam glyph_t SEG_3   = 7'h4F;
  localparam glyph_t SEG_4   = 7'h66;
  localparam glyph_t SEG_5   = 7'h6D;
  localparam glyph_t SEG_6   = 7'h7D;
  localparam glyph_t SEG_7   = 7'h07;
  localparam glyph_t SEG_8   = 7'h7F;
  localparam glyph_t SEG_9   = 7'h6F;
  localparam glyph_t SEG_A   = 7'h77;
  localparam glyph_t SEG_B   = 7'h7C;  // lowercase b
  localparam glyph_t SEG_C   = 7'h39;
  localparam glyph_t SEG_D   = 7'h5E;  // lowercase d
  localparam glyph_t SEG_E   = 7'h79;
  localparam glyph_t SEG_F   = 7'h71;

  typedef enum logic {
    PEND_EMPTY = 1'b0,
    PEND_FULL  = 1'b1
  } pend_state_t;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational 4-bit to 7-segment hex glyph lookup, active-high {g,f,e,d,c,b,a}.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  always_comb begin
    unique case (nibble)
      4'h0: glyph = SEG_0;
      4'h1: glyph = SEG_1;
      4'h2: glyph = SEG_2;
      4'h3: glyph = SEG_3;
      4'h4: glyph = SEG_4;
      4'h5: glyph = SEG_5;
      4'h6: glyph = SEG_6;
      4'h7: glyph = SEG_7;
      4'h8: glyph = SEG_8;
      4'h9: glyph = SEG_9;
      4'hA: glyph = SEG_A;
      4'hB: glyph = SEG_B;
      4'hC: glyph = SEG_C;
      4'hD: glyph = SEG_D;
      4'hE: glyph = SEG_E;
      4'hF: glyph = SEG_F;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with frame-synchronous word commit.
// Optional build macro SEG7_LEAD_ZERO_BLANK_EN blanks leading-zero digits (digit 0 always shown).
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_tick
);

  localparam int DIG_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRESC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 1);
  localparam logic [PRESC_W-1:0] BLANK_END  = PRESC_W'(BLANK_CYCLES);
  localparam logic [DIG_W-1:0]   DIG_LAST   = DIG_W'(NUM_DIGITS - 1);

  logic [PRESC_W-1:0]      presc_q;
  logic [DIG_W-1:0]        digit_q;
  logic [4*NUM_DIGITS-1:0] disp_q;
  logic [NUM_DIGITS-1:0]   disp_dp_q;
  logic [4*NUM_DIGITS-1:0] pend_data_q;
  logic [NUM_DIGITS-1:0]   pend_dp_q;
  pend_state_t             pend_state_q;
  pend_state_t             pend_state_d;

  logic                    slot_wrap;
  logic                    frame_wrap;
  logic                    load_fire;
  logic                    commit;
  logic [3:0]              cur_nibble;
  logic                    cur_dp;
  logic                    cur_blank;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic [6:0]              dec_glyph;

  assign slot_wrap  = (presc_q == PRESC_LAST);
  assign frame_wrap = slot_wrap && (digit_q == DIG_LAST);
  assign load_ready = (pend_state_q == PEND_EMPTY);
  assign load_fire  = load_valid && load_ready;
  assign commit     = frame_wrap && (pend_state_q == PEND_FULL);

  // Scan timebase: prescaler and digit index.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q    <= '0;
      digit_q    <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_wrap;
      if (slot_wrap) begin
        presc_q <= '0;
        digit_q <= (digit_q == DIG_LAST) ? '0 : digit_q + DIG_W'(1);
      end else begin
        presc_q <= presc_q + PRESC_W'(1);
      end
    end
  end

  // Pending-word state: EMPTY accepts a word, FULL holds it until the frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_state_q <= PEND_EMPTY;
    else        pend_state_q <= pend_state_d;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    pend_state_d = pend_state_q;
    unique case (pend_state_q)
      PEND_EMPTY: if (load_fire) pend_state_d = PEND_FULL;
      PEND_FULL:  if (commit)    pend_state_d = PEND_EMPTY;
    endcase
  end

  // NOTE: the data registers are small and must read as zero after reset, so they are reset too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_data_q <= '0;
      pend_dp_q   <= '0;
      disp_q      <= '0;
      disp_dp_q   <= '0;
    end else begin
      if (load_fire) begin
        pend_data_q <= load_data;
        pend_dp_q   <= dp_in;
      end
      if (commit) begin
        disp_q    <= pend_data_q;
        disp_dp_q <= pend_dp_q;
      end
    end
  end

`ifdef SEG7_LEAD_ZERO_BLANK_EN
  // Walk from the most significant digit down; a digit blanks while everything above it is zero.
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    lz_mask    = '0;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      zero_above = zero_above && (disp_q[4*k +: 4] == 4'h0);
      lz_mask[k] = zero_above;
    end
  end
`else
  assign lz_mask = '0;
`endif

  always_comb begin
    cur_nibble = '0;
    cur_dp     = 1'b0;
    cur_blank  = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (digit_q == DIG_W'(k)) begin
        cur_nibble = disp_q[4*k +: 4];
        cur_dp     = disp_dp_q[k];
        cur_blank  = lz_mask[k];
      end
    end
  end

  seg7_hex_decode u_hex_decode (
    .nibble (cur_nibble),
    .glyph  (dec_glyph)
  );

  // Segment outputs lag the digit index by one cycle; blanking hides the stale glyph.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= SEG_OFF;
      dp  <= 1'b0;
    end else begin
      seg <= cur_blank ? SEG_OFF : dec_glyph;
      dp  <= cur_dp;
    end
  end

  always_comb begin
    an_n = '1;
    if (presc_q >= BLANK_END) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (digit_q == DIG_W'(k)) an_n[k] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed self-checking bench for seg7_scan_ctrl (NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2).
module tb_seg7_scan_ctrl;

  localparam int N = 4;

  logic          clk;
  logic          rst_n;
  logic          load_valid;
  logic          load_ready;
  logic [4*N-1:0] load_data;
  logic [N-1:0]  dp_in;
  logic [6:0]    seg;
  logic          dp;
  logic [N-1:0]  an_n;
  logic          frame_tick;

  int checks = 0;
  int errors = 0;
  int anode_viol = 0;
  int ft_bad = 0;
  int ft_cnt = 0;

  seg7_scan_ctrl #(
    .NUM_DIGITS   (N),
    .PRESCALE     (8),
    .BLANK_CYCLES (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .dp_in      (dp_in),
    .seg        (seg),
    .dp         (dp),
    .an_n       (an_n),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SEG7_LEAD_ZERO_BLANK_EN
  localparam logic [6:0] LZ_GLYPH = 7'h00;
`else
  localparam logic [6:0] LZ_GLYPH = 7'h3F;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Advance until frame_tick is seen; report cycles waited and whether load_ready rose early.
  task automatic wait_frame(output int n, output bit ready_seen);
    n = 0;
    ready_seen = 1'b0;
    while (!frame_tick && n < 100) begin
      tick();
      n++;
      if (!frame_tick && load_ready) ready_seen = 1'b1;
    end
  endtask

  // Called at slot start (prescaler 0); checks glyph, dp, blanking and anode, ends at next slot start.
  task automatic check_slot(input string tag, input logic [6:0] exp_seg, input logic exp_dp,
                            input logic [3:0] exp_an);
    tick();
    check({tag, "_seg_early"}, 32'(seg), 32'(exp_seg));
    check({tag, "_dp"}, 32'(dp), 32'(exp_dp));
    check({tag, "_blank"}, 32'(an_n), 32'hF);
    tick();
    check({tag, "_an"}, 32'(an_n), 32'(exp_an));
    check({tag, "_seg"}, 32'(seg), 32'(exp_seg));
    repeat (6) tick();
  endtask

  // Background monitors: at most one anode low, and frame_tick spacing of 32 cycles.
  always @(negedge clk) begin
    if (!rst_n) begin
      ft_cnt = 1;
    end else begin
      if ($countones(~an_n) > 1) anode_viol++;
      if (frame_tick) begin
        if (ft_cnt != 32) ft_bad++;
        ft_cnt = 1;
      end else begin
        ft_cnt++;
      end
    end
  end

  initial begin
    int  n;
    bit  rdy;

    rst_n      = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    dp_in      = '0;

    // Reset state
    repeat (3) tick();
    check("rst_an_n", 32'(an_n), 32'hF);
    check("rst_seg", 32'(seg), 32'h0);
    check("rst_dp", 32'(dp), 32'h0);
    check("rst_ready", 32'(load_ready), 32'h1);
    check("rst_ft", 32'(frame_tick), 32'h0);

    // Release: cycle 0 is before the first edge
    #1 rst_n = 1'b1;
    check("c0_an", 32'(an_n), 32'hF);
    tick();
    check("c1_an", 32'(an_n), 32'hF);
    check("c1_seg", 32'(seg), 32'h3F);
    tick();
    check("c2_an", 32'(an_n), 32'hE);
    repeat (6) tick();
    check("c8_an", 32'(an_n), 32'hF);
    repeat (2) tick();
    check("c10_an", 32'(an_n), 32'hD);
    wait_frame(n, rdy);
    check("first_frame_at", 32'(n), 32'd22);

    // Mid-frame load of 1A3F, dp on digit 1
    repeat (10) tick();
    check("ld1_ready_before", 32'(load_ready), 32'h1);
    load_valid = 1'b1;
    load_data  = 16'h1A3F;
    dp_in      = 4'b0010;
    tick();
    load_valid = 1'b0;
    check("ld1_ready_after", 32'(load_ready), 32'h0);
    wait_frame(n, rdy);
    check("ld1_wait", 32'(n), 32'd21);
    check("ld1_ready_held_low", 32'(rdy), 32'h0);
    check("ld1_ready_commit", 32'(load_ready), 32'h1);
    check_slot("f1a3f_d0", 7'h71, 1'b0, 4'hE);
    check_slot("f1a3f_d1", 7'h4F, 1'b1, 4'hD);
    check_slot("f1a3f_d2", 7'h77, 1'b0, 4'hB);
    check_slot("f1a3f_d3", 7'h06, 1'b0, 4'h7);
    check("f1a3f_tick", 32'(frame_tick), 32'h1);

    // Back-to-back: 1234 accepted now, 5678 held valid and accepted right after the commit
    load_valid = 1'b1;
    load_data  = 16'h1234;
    dp_in      = 4'b0000;
    tick();
    load_data  = 16'h5678;
    check("b2b_ready_low", 32'(load_ready), 32'h0);
    wait_frame(n, rdy);
    check("b2b_wait", 32'(n), 32'd31);
    check("b2b_ready_held_low", 32'(rdy), 32'h0);
    check("b2b_ready_commit", 32'(load_ready), 32'h1);
    check_slot("f1234_d0", 7'h66, 1'b0, 4'hE);
    check("b2b_second_taken", 32'(load_ready), 32'h0);
    check_slot("f1234_d1", 7'h4F, 1'b0, 4'hD);
    check_slot("f1234_d2", 7'h5B, 1'b0, 4'hB);
    check_slot("f1234_d3", 7'h06, 1'b0, 4'h7);
    check("f1234_tick", 32'(frame_tick), 32'h1);
    check("f5678_ready", 32'(load_ready), 32'h1);
    load_valid = 1'b0;
    check_slot("f5678_d0", 7'h7F, 1'b0, 4'hE);
    check_slot("f5678_d1", 7'h07, 1'b0, 4'hD);
    check_slot("f5678_d2", 7'h7D, 1'b0, 4'hB);
    check_slot("f5678_d3", 7'h6D, 1'b0, 4'h7);

    // Reset mid-frame with a word pending
    load_valid = 1'b1;
    load_data  = 16'h9999;
    dp_in      = 4'b1111;
    tick();
    load_valid = 1'b0;
    check("mid_pending", 32'(load_ready), 32'h0);
    repeat (5) tick();
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_an", 32'(an_n), 32'hF);
    check("mid_rst_seg", 32'(seg), 32'h0);
    check("mid_rst_dp", 32'(dp), 32'h0);
    check("mid_rst_ready", 32'(load_ready), 32'h1);
    check("mid_rst_ft", 32'(frame_tick), 32'h0);
    tick();
    #1 rst_n = 1'b1;
    wait_frame(n, rdy);
    check("mid_rst_frame", 32'(n), 32'd32);
    check_slot("fzero_d0", 7'h3F, 1'b0, 4'hE);
    check_slot("fzero_d1", LZ_GLYPH, 1'b0, 4'hD);
    check_slot("fzero_d2", LZ_GLYPH, 1'b0, 4'hB);
    check_slot("fzero_d3", LZ_GLYPH, 1'b0, 4'h7);

    // Leading zeros: 0040, dp on blankable digit 2
    load_valid = 1'b1;
    load_data  = 16'h0040;
    dp_in      = 4'b0100;
    tick();
    load_valid = 1'b0;
    wait_frame(n, rdy);
    check("lz_wait", 32'(n), 32'd31);
    check_slot("f0040_d0", 7'h3F, 1'b0, 4'hE);
    check_slot("f0040_d1", 7'h66, 1'b0, 4'hD);
    check_slot("f0040_d2", LZ_GLYPH, 1'b1, 4'hB);
    check_slot("f0040_d3", LZ_GLYPH, 1'b0, 4'h7);

    check("anode_onehot", 32'(anode_viol), 32'd0);
    check("frame_period", 32'(ft_bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
